// File: rtl/pwr_switch_ack_model_pkg.sv
// Shared types and constants for the power-switch acknowledge model:
// channel state encoding and the jitter LFSR definition.
package pwr_switch_ack_model_pkg;

    typedef enum logic [1:0] {
        ST_ON        = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_OFF       = 2'd2,
        ST_RAMP_UP   = 2'd3
    } pwr_sw_state_e;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11 in right-shift form.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic is_ramp(input pwr_sw_state_e s);
        return (s == ST_RAMP_DOWN) || (s == ST_RAMP_UP);
    endfunction

endpackage

// File: rtl/pwr_switch_ack_ch.sv
// One power-switch channel: ON/RAMP_DOWN/OFF/RAMP_UP FSM with a down-counter,
// registered ack_n, busy and abort outputs. Extra latency arrives on jitter_i.
module pwr_switch_ack_ch
    import pwr_switch_ack_model_pkg::*;
#(
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15,
    parameter int RESET_ON    = 1,
    parameter int JITTER_W    = 3,
    parameter int CNT_W       = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                switch_n_i,
    input  logic [JITTER_W-1:0] jitter_i,
    output logic                switch_ack_n_o,
    output logic                busy_o,
    output logic                abort_o
);

    localparam pwr_sw_state_e    RESET_STATE = (RESET_ON != 0) ? ST_ON : ST_OFF;
    localparam logic [CNT_W-1:0] ON_LOAD     = CNT_W'(ON_LATENCY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_LATENCY - 1);

    pwr_sw_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] jitter_ext;
    logic             ack_n_d;
    logic             abort_d;

    assign jitter_ext = CNT_W'(jitter_i);

    // NOTE: asynchronous reset puts every register, state included, back to
    // its reset value immediately; non-blocking assignments keep all
    // registers updating from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= RESET_STATE;
            cnt_q          <= '0;
            switch_ack_n_o <= (RESET_STATE == ST_OFF);
            busy_o         <= 1'b0;
            abort_o        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            switch_ack_n_o <= ack_n_d;
            busy_o         <= is_ramp(state_q);
            abort_o        <= abort_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ON: begin
                if (switch_n_i) begin
                    state_d = ST_RAMP_DOWN;
                    cnt_d   = OFF_LOAD + jitter_ext;
                end
            end
            ST_RAMP_DOWN: begin
                if (!switch_n_i) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (!switch_n_i) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = ON_LOAD + jitter_ext;
                end
            end
            ST_RAMP_UP: begin
                if (switch_n_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reversal is tested before cnt==0, so it wins on the final ramp edge.
    always_comb begin
        ack_n_d = switch_ack_n_o;
        abort_d = 1'b0;
        unique case (state_q)
            ST_RAMP_DOWN: begin
                if (!switch_n_i)      abort_d = 1'b1;
                else if (cnt_q == '0) ack_n_d = 1'b1;
            end
            ST_RAMP_UP: begin
                if (switch_n_i)       abort_d = 1'b1;
                else if (cnt_q == '0) ack_n_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pwr_switch_ack_model.sv
// Power-switch acknowledge model: NUM_CH independent channels plus settled_o.
// Define PWR_SWITCH_ACK_JITTER_EN to add LFSR-driven random extra ramp latency.
module pwr_switch_ack_model
    import pwr_switch_ack_model_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15,
    parameter int RESET_ON    = 1,
    parameter int JITTER_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] switch_n_i,
    output logic [NUM_CH-1:0] switch_ack_n_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] abort_o,
    output logic              settled_o
);

    localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 2**JITTER_W) + 1;

    logic [NUM_CH-1:0][JITTER_W-1:0] jitter;

`ifdef PWR_SWITCH_ACK_JITTER_EN
    logic [LFSR_W-1:0]     lfsr_q;
    logic [2*JITTER_W-1:0] lfsr_dbl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_next(lfsr_q);
    end

    // Doubling the low bits lets a fixed slice implement a left rotation.
    assign lfsr_dbl = {2{lfsr_q[JITTER_W-1:0]}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_jitter
        localparam int ROT = i % JITTER_W;
        assign jitter[i] = lfsr_dbl[2*JITTER_W-1-ROT -: JITTER_W];
    end
`else
    assign jitter = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwr_switch_ack_ch #(
            .ON_LATENCY  (ON_LATENCY),
            .OFF_LATENCY (OFF_LATENCY),
            .RESET_ON    (RESET_ON),
            .JITTER_W    (JITTER_W),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .switch_n_i     (switch_n_i[i]),
            .jitter_i       (jitter[i]),
            .switch_ack_n_o (switch_ack_n_o[i]),
            .busy_o         (busy_o[i]),
            .abort_o        (abort_o[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) settled_o <= 1'b1;
        else         settled_o <= ~|busy_o;
    end

endmodule

// File: tb/tb_pwr_switch_ack_model.sv
// Directed bench for pwr_switch_ack_model: three configurations (15/15 reset-on,
// 3/20 reset-off, 1/1 reset-on); jitter range test when PWR_SWITCH_ACK_JITTER_EN.
module tb_pwr_switch_ack_model;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0] sw_a = 4'b0000;
    logic [3:0] ack_a, busy_a, abort_a;
    logic       settled_a;

    logic [3:0] sw_b = 4'b1111;
    logic [3:0] ack_b, busy_b, abort_b;
    logic       settled_b;

    logic [1:0] sw_c = 2'b00;
    logic [1:0] ack_c, busy_c, abort_c;
    logic       settled_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwr_switch_ack_model #(.NUM_CH(4), .ON_LATENCY(15), .OFF_LATENCY(15), .RESET_ON(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_a), .switch_ack_n_o(ack_a),
        .busy_o(busy_a), .abort_o(abort_a), .settled_o(settled_a));

    pwr_switch_ack_model #(.NUM_CH(4), .ON_LATENCY(3), .OFF_LATENCY(20), .RESET_ON(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_b), .switch_ack_n_o(ack_b),
        .busy_o(busy_b), .abort_o(abort_b), .settled_o(settled_b));

    pwr_switch_ack_model #(.NUM_CH(2), .ON_LATENCY(1), .OFF_LATENCY(1), .RESET_ON(1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_c), .switch_ack_n_o(ack_c),
        .busy_o(busy_c), .abort_o(abort_c), .settled_o(settled_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive req on dut_a; c counts edges after the sampling edge k (c=0 is edge k).
    // rev>0 restores 'back' so it is sampled at edge k+rev.
    task automatic ramp_a(input string tag, input logic [3:0] req, input logic [3:0] back,
                          input int rev, input int lat, input int ch,
                          input logic [3:0] ack0, input int ncyc);
        logic [3:0] bit_m, e_ack, e_busy, e_abort;
        int         last;
        bit_m = 4'b0001 << ch;
        last  = (rev > 0) ? rev : lat;
        sw_a  = req;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            e_ack   = (rev == 0 && c >= lat) ? (ack0 ^ bit_m) : ack0;
            e_busy  = (c >= 1 && c <= last) ? bit_m : 4'b0000;
            e_abort = (rev > 0 && c == rev) ? bit_m : 4'b0000;
            check({tag, "_ack"},     ack_a,     e_ack);
            check({tag, "_busy"},    busy_a,    e_busy);
            check({tag, "_abort"},   abort_a,   e_abort);
            check({tag, "_settled"}, settled_a, (c >= 2 && c <= last + 1) ? 1'b0 : 1'b1);
            if (rev > 0 && c == rev - 1) sw_a = back;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_ack_a",     ack_a,     4'b0000);
        check("rst_busy_a",    busy_a,    4'b0000);
        check("rst_abort_a",   abort_a,   4'b0000);
        check("rst_settled_a", settled_a, 1'b1);
        check("rst_ack_b",     ack_b,     4'b1111);
        check("rst_settled_b", settled_b, 1'b1);
        check("rst_ack_c",     ack_c,     2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef PWR_SWITCH_ACK_JITTER_EN
        begin
            logic [31:0] seen;
            logic        target, done;
            int          lat;
            seen   = '0;
            target = 1'b0;
            for (int r = 0; r < 200; r++) begin
                target  = ~target;
                sw_a[0] = target;
                done    = 1'b0;
                lat     = -1;
                for (int c = 0; c <= 40 && !done; c++) begin
                    @(posedge clk); #1;
                    if (ack_a[0] == target) begin
                        lat  = c;
                        done = 1'b1;
                    end
                end
                check("jit_lat_in_range", (lat >= 15 && lat <= 22), 1'b1);
                if (lat >= 0 && lat < 32) seen[lat] = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
            check("jit_distinct", ($countones(seen) >= 2), 1'b1);
        end
`else
        // dut_a: power-down, aborts in both directions, power-up.
        ramp_a("down0",    4'b0001, 4'b0001,  0, 15, 0, 4'b0000, 18);
        ramp_a("abort5",   4'b0011, 4'b0001,  5, 15, 1, 4'b0001,  9);
        ramp_a("abort15",  4'b0011, 4'b0001, 15, 15, 1, 4'b0001, 18);
        ramp_a("up_abort", 4'b0000, 4'b0001,  7, 15, 0, 4'b0001, 10);
        ramp_a("up0",      4'b0000, 4'b0000,  0, 15, 0, 4'b0001, 17);

        // dut_b: bring ch3 up, then ch2 up and ch3 down on the same edge.
        sw_b = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("b_up3_ack", ack_b, (c >= 3) ? 4'b0111 : 4'b1111);
        end
        sw_b = 4'b1011;
        for (int c = 0; c < 22; c++) begin
            logic [3:0] e_ack, e_busy;
            @(posedge clk); #1;
            e_ack  = {(c >= 20), (c < 3), 2'b11};
            e_busy = {(c >= 1 && c <= 20), (c >= 1 && c <= 3), 2'b00};
            check("par_ack",     ack_b,     e_ack);
            check("par_busy",    busy_b,    e_busy);
            check("par_settled", settled_b, (c >= 2 && c <= 21) ? 1'b0 : 1'b1);
        end

        // dut_c: unit latency. A one-cycle pulse is reversed on its exit edge,
        // so it aborts; a two-cycle request yields a two-cycle ack pulse.
        sw_c = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("l1_ack",  ack_c,  (c >= 1) ? 2'b01 : 2'b00);
            check("l1_busy", busy_c, (c == 1) ? 2'b01 : 2'b00);
        end
        sw_c = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) sw_c = 2'b01;
            check("l1_pulse1_ack",   ack_c,   2'b01);
            check("l1_pulse1_abort", abort_c, (c == 1) ? 2'b10 : 2'b00);
            check("l1_pulse1_busy",  busy_c,  (c == 1) ? 2'b10 : 2'b00);
        end
        sw_c = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) sw_c = 2'b01;
            check("l1_pulse2_ack",   ack_c,   (c == 1 || c == 2) ? 2'b11 : 2'b01);
            check("l1_pulse2_abort", abort_c, 2'b00);
        end

        // Reset asserted mid-ramp on dut_a ch2, between clock edges.
        sw_a = 4'b0100;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack_a",     ack_a,     4'b0000);
        check("mid_rst_busy_a",    busy_a,    4'b0000);
        check("mid_rst_abort_a",   abort_a,   4'b0000);
        check("mid_rst_settled_a", settled_a, 1'b1);
        check("mid_rst_ack_b",     ack_b,     4'b1111);
        check("mid_rst_ack_c",     ack_c,     2'b00);
        sw_a = 4'b0000;
        sw_b = 4'b1111;
        sw_c = 2'b00;
        @(posedge clk); #1;
        check("in_rst_abort_a", abort_a, 4'b0000);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_ack_a",     ack_a,     4'b0000);
            check("post_rst_busy_a",    busy_a,    4'b0000);
            check("post_rst_abort_a",   abort_a,   4'b0000);
            check("post_rst_settled_a", settled_a, 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
